// File: rtl/rf_fifo_ctrl_23x64_if.sv
// Push/pop handshake bundle for rf_fifo_ctrl_23x64.
//   flush_i             synchronous clear of all FIFO contents
//   push_val_i/rdy_o    push handshake, push_dat_i carries the word
//   pop_val_o/rdy_i     pop handshake, pop_dat_o carries the head word
//   cnt_o               total words held (RF + in-flight read + output buffer)
// slave modport: FIFO side; master modport: producer/consumer side.
interface rf_fifo_ctrl_23x64_if #(
  parameter int unsigned Word_Width = 23,
  parameter int unsigned Addr_Width = 6
) ();
  logic                  flush_i;
  logic                  push_val_i;
  logic                  push_rdy_o;
  logic [Word_Width-1:0] push_dat_i;
  logic                  pop_val_o;
  logic                  pop_rdy_i;
  logic [Word_Width-1:0] pop_dat_o;
  logic [Addr_Width:0]   cnt_o;

  modport slave (
    input  flush_i, push_val_i, push_dat_i, pop_rdy_i,
    output push_rdy_o, pop_val_o, pop_dat_o, cnt_o
  );

  modport master (
    output flush_i, push_val_i, push_dat_i, pop_rdy_i,
    input  push_rdy_o, pop_val_o, pop_dat_o, cnt_o
  );
endinterface

// File: rtl/rf_fifo_ctrl_23x64.sv
// Show-ahead FIFO controller around a 23x64 two-port register file.
// Pushes become port-B writes, reads are issued on port A, and a 2-entry
// output buffer absorbs the RF's one-cycle read latency so one push and one
// pop can complete every cycle.
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   bus (slave)      flush / push / pop handshakes and word count
//   mem_cena_o       RF port-A read enable (active-low), mem_addra_o address
//   mem_dataa_i      RF read data, valid the cycle after a read edge
//   mem_cenb_o       RF port-B enable (active-low), mem_wenb_o write enable
//   mem_addrb_o      RF write address, mem_datab_o write data
module rf_fifo_ctrl_23x64 #(
  parameter int unsigned Word_Width = 23,
  parameter int unsigned Addr_Width = 6
) (
  input  logic                  clk,
  input  logic                  rstn,
  rf_fifo_ctrl_23x64_if.slave   bus,
  output logic                  mem_cena_o,
  output logic [Addr_Width-1:0] mem_addra_o,
  input  logic [Word_Width-1:0] mem_dataa_i,
  output logic                  mem_cenb_o,
  output logic                  mem_wenb_o,
  output logic [Addr_Width-1:0] mem_addrb_o,
  output logic [Word_Width-1:0] mem_datab_o
);

  localparam int unsigned DEPTH = 1 << Addr_Width;
  localparam int unsigned CW    = Addr_Width + 1;

  logic [Addr_Width-1:0] wr_ptr_q, wr_ptr_d;
  logic [Addr_Width-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         ram_cnt_q, ram_cnt_d;
  logic                  rd_pend_q, rd_pend_d;
  logic [1:0]            out_cnt_q, out_cnt_d;
  logic [Word_Width-1:0] ob0_q, ob0_d;
  logic [Word_Width-1:0] ob1_q, ob1_d;
  logic                  push_rdy_q, push_rdy_d;
  logic                  pop_val_q, pop_val_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic                  push_fire;
  logic                  pop_fire;
  logic                  rd_issue;
  logic [2:0]            occ;
  logic [1:0]            out_after;

  // Flush wins over both handshakes, so neither side fires in a flush cycle.
  assign push_fire = bus.push_val_i & push_rdy_q & ~bus.flush_i;
  assign pop_fire  = pop_val_q & bus.pop_rdy_i & ~bus.flush_i;

  // Buffer slots that will be committed after this cycle's pop; a new read
  // is only issued if its data is guaranteed a free slot next cycle.
  assign occ      = {1'b0, out_cnt_q} + {2'b00, rd_pend_q} - {2'b00, pop_fire};
  assign rd_issue = (ram_cnt_q != '0) & (occ <= 3'd1) & ~bus.flush_i;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ram_cnt_d  = ram_cnt_q;
    rd_pend_d  = rd_pend_q;
    out_cnt_d  = out_cnt_q;
    ob0_d      = ob0_q;
    ob1_d      = ob1_q;
    push_rdy_d = push_rdy_q;
    pop_val_d  = pop_val_q;
    cnt_d      = cnt_q;
    out_after  = out_cnt_q - {1'b0, pop_fire};

    if (bus.flush_i) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      ram_cnt_d  = '0;
      rd_pend_d  = 1'b0;
      out_cnt_d  = '0;
      push_rdy_d = 1'b0;
      pop_val_d  = 1'b0;
      cnt_d      = '0;
    end else begin
      if (push_fire) wr_ptr_d = wr_ptr_q + Addr_Width'(1'b1);
      if (rd_issue)  rd_ptr_d = rd_ptr_q + Addr_Width'(1'b1);
      ram_cnt_d = ram_cnt_q + CW'(push_fire) - CW'(rd_issue);
      rd_pend_d = rd_issue;

      // Pop shifts first, then returning read data lands in the first free slot.
      if (pop_fire) ob0_d = ob1_q;
      if (rd_pend_q) begin
        if (out_after == 2'd0) ob0_d = mem_dataa_i;
        else                   ob1_d = mem_dataa_i;
      end
      out_cnt_d = out_after + {1'b0, rd_pend_q};

      push_rdy_d = (ram_cnt_d < CW'(DEPTH));
      pop_val_d  = (out_cnt_d != 2'd0);
      cnt_d      = ram_cnt_d + CW'(rd_pend_d) + CW'(out_cnt_d);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ram_cnt_q  <= '0;
      rd_pend_q  <= 1'b0;
      out_cnt_q  <= '0;
      ob0_q      <= '0;
      ob1_q      <= '0;
      push_rdy_q <= 1'b0;
      pop_val_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ram_cnt_q  <= ram_cnt_d;
      rd_pend_q  <= rd_pend_d;
      out_cnt_q  <= out_cnt_d;
      ob0_q      <= ob0_d;
      ob1_q      <= ob1_d;
      push_rdy_q <= push_rdy_d;
      pop_val_q  <= pop_val_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.push_rdy_o = push_rdy_q;
  assign bus.pop_val_o  = pop_val_q;
  assign bus.pop_dat_o  = ob0_q;
  assign bus.cnt_o      = cnt_q;

  assign mem_cena_o  = ~rd_issue;
  assign mem_addra_o = rd_ptr_q;
  assign mem_cenb_o  = ~push_fire;
  assign mem_wenb_o  = ~push_fire;
  assign mem_addrb_o = wr_ptr_q;
  assign mem_datab_o = bus.push_dat_i;

  a_ram_cnt: assert property (@(posedge clk) disable iff (!rstn)
    ram_cnt_q <= CW'(DEPTH));
  a_out_cnt: assert property (@(posedge clk) disable iff (!rstn)
    out_cnt_q <= 2'd2);
  a_no_underflow: assert property (@(posedge clk) disable iff (!rstn)
    !(pop_fire && out_cnt_q == 2'd0));
  a_no_collision: assert property (@(posedge clk) disable iff (!rstn)
    !(rd_issue && push_fire && rd_ptr_q == wr_ptr_q));

endmodule

// File: tb/tb_rf_fifo_ctrl_23x64.sv
module tb_rf_fifo_ctrl_23x64;

  logic        clk = 1'b0;
  logic        rstn;
  logic        mem_cena_o, mem_cenb_o, mem_wenb_o;
  logic [5:0]  mem_addra_o, mem_addrb_o;
  logic [22:0] mem_dataa_i, mem_datab_o;
  logic [22:0] rf [64];

  rf_fifo_ctrl_23x64_if #(.Word_Width(23), .Addr_Width(6)) bus ();

  rf_fifo_ctrl_23x64 #(.Word_Width(23), .Addr_Width(6)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .bus         (bus),
    .mem_cena_o  (mem_cena_o),
    .mem_addra_o (mem_addra_o),
    .mem_dataa_i (mem_dataa_i),
    .mem_cenb_o  (mem_cenb_o),
    .mem_wenb_o  (mem_wenb_o),
    .mem_addrb_o (mem_addrb_o),
    .mem_datab_o (mem_datab_o)
  );

  always #5 clk = ~clk;

  // Register-file model: synchronous write, registered read data.
  always @(posedge clk) begin
    if (!mem_cenb_o && !mem_wenb_o) rf[mem_addrb_o] <= mem_datab_o;
    if (!mem_cena_o) mem_dataa_i <= rf[mem_addra_o];
  end

  int n_chk = 0, n_bad = 0;
  int cyc = 0;
  int n_push, n_pops, first_push_cyc, first_val_cyc, first_pop_cyc, last_pop_cyc;
  logic        obs_pop_val, obs_push_rdy;
  logic [6:0]  obs_cnt;
  logic [22:0] sb [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clr_stats();
    n_push = 0; n_pops = 0;
    first_push_cyc = -1; first_val_cyc = -1; first_pop_cyc = -1; last_pop_cyc = -1;
  endtask

  // One clock cycle: observe registered outputs, drive inputs, and predict
  // which handshakes fire on the coming rising edge.
  task automatic step(input logic pv, input logic [22:0] pd, input logic pr, input logic fl);
    logic push_f, pop_f;
    logic [22:0] exp;
    @(negedge clk);
    cyc++;
    obs_pop_val  = bus.pop_val_o;
    obs_push_rdy = bus.push_rdy_o;
    obs_cnt      = bus.cnt_o;
    check("cnt", 32'(obs_cnt), 32'(sb.size()));
    if (obs_pop_val && first_val_cyc < 0) first_val_cyc = cyc;
    bus.push_val_i = pv;
    bus.push_dat_i = pd;
    bus.pop_rdy_i  = pr;
    bus.flush_i    = fl;
    #1;
    if (!mem_cena_o && !mem_cenb_o)
      check("addr_coll", {31'b0, mem_addra_o == mem_addrb_o}, 32'd0);
    push_f = pv && obs_push_rdy && !fl;
    pop_f  = obs_pop_val && pr && !fl;
    if (fl) begin
      sb.delete();
    end else begin
      if (pop_f) begin
        if (sb.size() == 0) check("pop_avail", 32'(sb.size()), 32'd1);
        else begin
          exp = sb.pop_front();
          check("pop_dat", 32'(bus.pop_dat_o), 32'(exp));
        end
        n_pops++;
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
      end
      if (push_f) begin
        sb.push_back(pd);
        n_push++;
        if (first_push_cyc < 0) first_push_cyc = cyc;
      end
    end
  endtask

  task automatic drain(input string tag, input int budget);
    for (int g = 0; g < budget && sb.size() != 0; g++) step(1'b0, '0, 1'b1, 1'b0);
    check(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int maxcnt, bubbles, p_push, p_pop, guard;
    bus.flush_i = 1'b0; bus.push_val_i = 1'b0; bus.push_dat_i = '0; bus.pop_rdy_i = 1'b0;
    rstn = 1'b0;
    clr_stats();

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_push_rdy", 32'(bus.push_rdy_o), 32'd0);
    check("rst_pop_val",  32'(bus.pop_val_o),  32'd0);
    check("rst_pop_dat",  32'(bus.pop_dat_o),  32'd0);
    check("rst_cnt",      32'(bus.cnt_o),      32'd0);
    check("rst_cena",     32'(mem_cena_o),     32'd1);
    check("rst_cenb",     32'(mem_cenb_o),     32'd1);
    check("rst_wenb",     32'(mem_wenb_o),     32'd1);
    rstn = 1'b1;
    #1;
    check("rdy_before_edge", 32'(bus.push_rdy_o), 32'd0);
    step(1'b0, '0, 1'b0, 1'b0);
    check("rdy_after_edge", 32'(obs_push_rdy), 32'd1);

    // Five words, consumer always ready
    clr_stats();
    for (int i = 0; i < 5; i++) step(1'b1, 23'(i + 1), 1'b1, 1'b0);
    drain("t1_drain", 20);
    check("t1_latency", 32'(first_val_cyc - first_push_cyc), 32'd3);
    check("t1_npops",   32'(n_pops), 32'd5);
    check("t1_b2b",     32'(last_pop_cyc - first_pop_cyc), 32'd4);
    step(1'b0, '0, 1'b0, 1'b0);
    check("t1_cnt0", 32'(obs_cnt), 32'd0);

    // Fill to capacity with the consumer stalled, then drain across wrap
    clr_stats();
    for (int i = 0; i < 80; i++) step(1'b1, 23'(32'h100 + n_push), 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b0);
    check("t2_accepted", 32'(n_push), 32'd66);
    check("t2_cnt66",    32'(obs_cnt), 32'd66);
    check("t2_rdy_low",  32'(obs_push_rdy), 32'd0);
    check("t2_val",      32'(obs_pop_val), 32'd1);
    check("t2_head",     32'(bus.pop_dat_o), 32'h100);
    drain("t2_drain", 300);
    check("t2_npops", 32'(n_pops), 32'd66);

    // Continuous streaming
    clr_stats();
    maxcnt = 0; bubbles = 0;
    for (int i = 0; i < 260 && n_pops < 200; i++) begin
      step(n_push < 200, 23'(32'h1000 + n_push), 1'b1, 1'b0);
      if (int'(obs_cnt) > maxcnt) maxcnt = int'(obs_cnt);
      if (first_val_cyc >= 0 && !obs_pop_val && n_pops < 200) bubbles++;
    end
    check("t3_npops",   32'(n_pops), 32'd200);
    check("t3_bubbles", 32'(bubbles), 32'd0);
    check("t3_maxcnt",  32'(maxcnt), 32'd3);
    check("t3_span",    32'(last_pop_cyc - first_push_cyc), 32'd202);

    // Flush with 10 words held and a read in flight
    clr_stats();
    for (int i = 0; i < 10; i++) step(1'b1, 23'(32'h2000 + i), 1'b0, 1'b0);
    step(1'b1, 23'h2010, 1'b1, 1'b0);
    step(1'b1, 23'h7abcde, 1'b1, 1'b1);
    check("fl_cnt_before", 32'(obs_cnt), 32'd10);
    step(1'b1, 23'h055555, 1'b1, 1'b0);
    check("fl_cnt0",  32'(obs_cnt), 32'd0);
    check("fl_val0",  32'(obs_pop_val), 32'd0);
    check("fl_rdy0",  32'(obs_push_rdy), 32'd0);
    clr_stats();
    step(1'b1, 23'h033333, 1'b1, 1'b0);
    check("fl_push_ok", 32'(n_push), 32'd1);
    drain("fl_drain", 20);
    check("fl_latency", 32'(first_val_cyc - first_push_cyc), 32'd3);
    check("fl_npops",   32'(n_pops), 32'd1);

    // Random traffic with phases biased toward full, empty and balanced
    clr_stats();
    guard = 0;
    while (n_push < 10000 && guard < 40000) begin
      case ((guard / 500) % 3)
        0:       begin p_push = 90; p_pop = 30; end
        1:       begin p_push = 30; p_pop = 90; end
        default: begin p_push = 70; p_pop = 70; end
      endcase
      step($urandom_range(0, 99) < p_push, 23'($urandom), $urandom_range(0, 99) < p_pop, 1'b0);
      guard++;
    end
    check("rnd_pushed", 32'(n_push), 32'd10000);
    drain("rnd_drain", 400);
    check("rnd_npops", 32'(n_pops), 32'd10000);

    // Asynchronous reset mid-stream
    clr_stats();
    for (int i = 0; i < 8; i++) step(1'b1, 23'(32'h3000 + i), i[0], 1'b0);
    @(negedge clk);
    bus.push_val_i = 1'b0; bus.pop_rdy_i = 1'b0;
    #2 rstn = 1'b0;
    #1;
    sb.delete();
    check("ar_push_rdy", 32'(bus.push_rdy_o), 32'd0);
    check("ar_pop_val",  32'(bus.pop_val_o),  32'd0);
    check("ar_pop_dat",  32'(bus.pop_dat_o),  32'd0);
    check("ar_cnt",      32'(bus.cnt_o),      32'd0);
    check("ar_cena",     32'(mem_cena_o),     32'd1);
    check("ar_cenb",     32'(mem_cenb_o),     32'd1);
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    step(1'b0, '0, 1'b0, 1'b0);
    clr_stats();
    for (int i = 0; i < 3; i++) step(1'b1, 23'(32'h4000 + i), 1'b1, 1'b0);
    drain("ar_drain", 20);
    check("ar_latency", 32'(first_val_cyc - first_push_cyc), 32'd3);
    check("ar_npops",   32'(n_pops), 32'd3);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
